// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: memory-mapped UART transmitter on the core's data-memory port.
//
// Register window (8 bytes at BASE_ADDR; byte offsets alias onto their word):
//   +0 TXDATA  write pushes data_in[7:0] into the TX FIFO; reads return 0
//   +4 STATUS  read-only: {23'b0, count[4:0], overflow, busy, empty, full}
//              A read clears the sticky overflow bit.
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   addr      byte address from the core
//   data_in   store data (bits [7:0] used)
//   WE, RE    store / load strobes
//   by        access width (ignored; any width writes byte lane 0)
//   data_out  registered read data; 0 when not addressed, so it can be ORed
//             with the memory read data
//   tx        serial line, idle high, driven from a flop
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1);
// otherwise the frame is 8N1.
module riscv_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        WE,
    input  logic        RE,
    input  logic [1:0]  by,
    output logic [31:0] data_out,
    output logic        tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // Address decode
    logic hit, wr_data, rd_status;
    assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_data   = WE & hit & ~addr[2];
    assign rd_status = RE & hit & addr[2];

    logic unused_bits;
    assign unused_bits = ^{by, data_in[31:8], addr[1:0]};

    // TX FIFO; pointers carry one extra bit to tell full from empty
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, count;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];
    // A pop in the same cycle frees a slot, so a write while full still lands
    assign push  = wr_data & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Serialiser
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d, baud_last;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the next state so tx is a plain flop
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Status and read data
    logic        overflow_q, busy;
    logic [31:0] status;

    assign busy   = (state_q != StIdle);
    assign status = {23'b0, 5'(count), overflow_q, busy, empty, full};

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            data_out   <= '0;
        end else begin
            if (rd_status)                 overflow_q <= 1'b0;
            if (wr_data && full && !pop)   overflow_q <= 1'b1;
            if (RE)                        data_out   <= rd_status ? status : 32'h0;
        end
    end
endmodule

// File: tb/tb_riscv_uart_tx.sv
// Directed testbench for riscv_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// The line is logged one sample per cycle and compared against frames built
// from the bytes written; STATUS reads are compared against hand-computed words.
module tb_riscv_uart_tx;
    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned FL = CPB * FB;
    localparam logic [31:0] TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] STATUS = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  by = 2'b10;
    logic [31:0] data_out;
    logic        tx;

    always #5 clk = ~clk;

    riscv_uart_tx #(
        .BASE_ADDR    (32'hFFFF_0000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .WE       (we),
        .RE       (re),
        .by       (by),
        .data_out (data_out),
        .tx       (tx)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic cap_en   = 1'b0;
    logic log_q[$];
    logic exp_q[$];

    // One line sample per cycle, just after the edge
    always @(posedge clk) begin
        #1;
        if (cap_en) log_q.push_back(tx);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Each bus task is entered at a negedge and consumes exactly one rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; data_in = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    task automatic exp_frame(input logic [7:0] b);
        for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < int'(CPB); c++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < int'(CPB); c++) exp_q.push_back(^b);
`endif
        for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_line[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    logic [7:0] ovf_bytes [9];
    int         lows;

    initial begin
        ovf_bytes = '{8'h01, 8'h02, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h00, 8'hAA, 8'h99};

        // Reset and idle
        idle(2);
        reset = 1'b0;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_data_out", data_out, 32'h0);
        bus_read(STATUS);
        check("reset_status", data_out, 32'h0000_0002);

        // Single byte: tx goes low after E+1
        cap_en = 1'b1;
        bus_write(TXDATA, 32'h0000_00A5);
        idle(FL + 8);
        cap_en = 1'b0;
        exp_idle(1); exp_frame(8'hA5); exp_idle(7);
        compare_log("single");

        // Back-to-back: three frames with no gap; count 2 -> 1 -> 0
        cap_en = 1'b1;
        bus_write(TXDATA, 32'h55);
        bus_write(TXDATA, 32'h0F);
        bus_write(TXDATA, 32'hFF);
        bus_read(STATUS);
        check("b2b_status_e3", data_out, 32'h0000_0024);
        idle(16);
        bus_read(STATUS);
        check("b2b_status_f1", data_out, 32'h0000_0024);
        idle(FL - 11);
        bus_read(STATUS);
        check("b2b_status_f2", data_out, 32'h0000_0014);
        idle(FL - 1);
        bus_read(STATUS);
        check("b2b_status_f3", data_out, 32'h0000_0006);
        idle(FL);
        bus_read(STATUS);
        check("b2b_status_done", data_out, 32'h0000_0002);
        cap_en = 1'b0;
        exp_idle(1); exp_frame(8'h55); exp_frame(8'h0F); exp_frame(8'hFF); exp_idle(8);
        compare_log("b2b");

        // Overflow: FSM busy on 0x11, then 9 writes into an 8-deep FIFO
        cap_en = 1'b1;
        bus_write(TXDATA, 32'h11);
        idle(2);
        for (int i = 0; i < 9; i++) bus_write(TXDATA, 32'(ovf_bytes[i]));
        bus_read(STATUS);
        check("ovf_status", data_out, 32'h0000_008D);
        bus_read(STATUS);
        check("ovf_cleared", data_out, 32'h0000_0085);
        idle(9 * FL);
        bus_read(STATUS);
        check("ovf_drained", data_out, 32'h0000_0002);
        cap_en = 1'b0;
        exp_idle(1); exp_frame(8'h11);
        for (int i = 0; i < 8; i++) exp_frame(ovf_bytes[i]);
        exp_idle(8);
        compare_log("ovf");

        // Decode miss, STATUS write ignored, read hold and TXDATA read
        bus_write(32'hFFFF_0008, 32'h5A);
        bus_write(STATUS, 32'h77);
        bus_read(STATUS);
        check("miss_status", data_out, 32'h0000_0002);
        idle(1);
        check("miss_hold", data_out, 32'h0000_0002);
        bus_read(32'h0000_1000);
        check("miss_read", data_out, 32'h0);
        bus_read(STATUS);
        bus_read(TXDATA);
        check("txdata_read", data_out, 32'h0);
        idle(5);
        check("miss_tx_idle", 32'(tx), 32'd1);

        // Reset mid-frame during DATA bit 3 with a second byte queued
        bus_write(TXDATA, 32'h96);
        bus_write(TXDATA, 32'h33);
        idle(17);
        check("mid_bit3", 32'(tx), 32'd0);
        reset = 1'b1;
        idle(1);
        check("mid_reset_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        bus_read(STATUS);
        check("mid_reset_status", data_out, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("mid_reset_discard", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
        cap_en = 1'b1;
        bus_write(TXDATA, 32'h07);
        idle(FL + 8);
        cap_en = 1'b0;
        exp_idle(1); exp_frame(8'h07); exp_idle(7);
        compare_log("parity");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/riscv_uart_tx.md
# riscv_uart_tx

Memory-mapped UART transmitter on the core's data-memory port, in parallel with `riscv_mem`.
- Decodes the core's address, write-enable and read-enable strobes.
- Queues store bytes in a FIFO and serialises them as 8N1 frames on `tx`.
- Returns a status word on loads.
- `data_out` reads zero when the block is not addressed, so it is ORed with the memory read data ahead of the data register.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_0000: base of the 8-byte register window; bits [2:0] must be zero.
- `CLKS_PER_BIT`, 868: clocks per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  32  byte address from the core's address register.
- `data_in`  in  32  store data; only bits [7:0] are used.
- `WE`  in  1  store strobe.
- `RE`  in  1  load strobe.
- `by`  in  2  access width; does not affect decode; any width writes byte lane 0.
- `data_out`  out  32  registered read data.
- `tx`  out  1  serial line; idle high.

## Operation
Address decode:
- `hit` = (`addr[31:3]` == `BASE_ADDR[31:3]`).
- Offset 0 is TXDATA.
- Offset 4 is STATUS.
- Offsets 1–3 and 5–7 alias onto their word.

TXDATA:
- A write (`WE` && `hit` && offset 0) pushes `data_in[7:0]`.
- A read returns 0.

STATUS (read-only):
- bit0 full
- bit1 empty
- bit2 busy (FSM not IDLE)
- bit3 overflow (sticky)
- bits[8:4] FIFO count
- all other bits 0

Overflow and register writes:
- A TXDATA write while full and with no pop in the same cycle is dropped and sets overflow.
- A read of STATUS clears overflow in the same edge that captures it. The read returns 1.
- Writes to STATUS are ignored.

FIFO:
- Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits; they wrap naturally.
- Full when the MSBs differ and the remaining bits are equal.
- When a push and a pop occur in the same cycle, both take effect. A push while full is therefore accepted if the FSM pops in that cycle.

Serialiser FSM: IDLE → START → DATA → STOP.
- IDLE: `tx`=1. If the FIFO is non-empty: pop, load the shift register, clear the baud counter, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: LSB first, 8 bits. Each bit lasts `CLKS_PER_BIT` cycles; a bit counter of 0..7 selects the bit. After bit 7, go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle: if the FIFO is non-empty, pop and go directly to START (no idle bit); otherwise go to IDLE.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits and counts 0..`CLKS_PER_BIT`-1.

`tx` is driven from a flop; there is no combinational path from state to pin.

## Timing
Reset values:
- `tx`=1, `data_out`=0.
- FSM=IDLE; FIFO empty; overflow=0; all counters 0.

Reset mid-frame:
- `tx` returns high on the reset edge.
- FIFO contents are discarded.
- The partial frame is abandoned.

Write-to-line latency:
- TXDATA write sampled at edge E into an empty FIFO while idle: pop at edge E+1, `tx` low after edge E+1.
- There is no bypass around the FIFO.

Frame timing:
- A frame lasts 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back frames have zero gap.

Read timing:
- `data_out` is updated at the edge where `RE` && `hit` is sampled and holds until the next such edge.
- Any other `RE` cycle loads 0.
- Cycles with `RE`=0 hold the previous value.

Simultaneous `WE` and `RE`: the write takes effect; `data_out` loads the STATUS value from before the edge.

## Configuration
`UART_TX_PARITY_EN`:
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles. Frame is 8E1, 11 bit-times.
- Undefined: no PARITY state, no parity logic. Frame is 8N1, 10 bit-times.

## Test plan
- **Reset and idle:** assert `reset` for 2 cycles, then release → `tx`=1, `data_out`=0, STATUS read = 32'h0000_0002.
- **Single byte** (`CLKS_PER_BIT`=4, `BASE_ADDR`=32'hFFFF_0000): write 32'h0000_00A5 to 32'hFFFF_0000 → `tx` low after edge E+1. Line sequence is 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. Line then stays high.
- **Back-to-back:** write 8'h55, 8'h0F, 8'hFF in consecutive cycles → three frames, 120 cycles total, no idle bit between frames. STATUS count goes 1,1,2 then decrements.
- **Overflow:** stall the FSM mid-frame; write 9 bytes with `FIFO_DEPTH`=8.
  - STATUS reads 32'h0000_008D (count=8, overflow, busy, full).
  - Next STATUS read has bit3=0.
  - The 9th byte never appears on `tx`.
- **Decode miss:** write to 32'hFFFF_0008 and read from 32'h0000_1000 → no FIFO push; `data_out`=0.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → `tx`=1 on the next edge; STATUS reads 32'h0000_0002. With `UART_TX_PARITY_EN` defined, sending 8'h07 gives a parity bit of 1.
